max7219_sequencer: RTL and testbench
====================================

MAX7219_SEQUENCER -- requirements
Module: max7219_sequencer

Interface
REQ-001 Parameter DIGIT_NUM, default 8, number of display digits driven (1..8).
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 Reset: reset, synchronous, active-low; clock: clock.
REQ-004 update_req  input  1  single-cycle request to refresh all digit registers.
REQ-005 num  input  DIGIT_NUM*4  BCD digits; bits [3:0] = LSD (digit 1).
REQ-006 dp  input  3  decimal-point position; 000 = LSD, 111 = MSD.
REQ-007 bright_req  input  1  single-cycle request to rewrite the intensity register.
REQ-008 brightness  input  4  intensity value 0..15.
REQ-009 frame_data  output  16  MAX7219 frame {4'h0, addr[3:0], data[7:0]}.
REQ-010 frame_valid  output  1  frame_data holds a frame to transmit.
REQ-011 frame_ready  input  1  serializer accepts frame this cycle.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 init_done  output  1  high once the init sequence has completed; stays high until reset.

Function
REQ-014 States: INIT, IDLE, BRIGHT, DIGITS.
REQ-015 Transfer occurs on any cycle with frame_valid and frame_ready both high; frame_data SHALL stay stable while frame_valid is high and frame_ready is low.
REQ-016 After a transfer, if more frames remain in the current state, frame_valid SHALL stay high and frame_data SHALL show the next frame on the following cycle (no bubble).
REQ-017 INIT sends, in order: 0x0C01 (normal operation), 0x09FF (Code-B decode all digits), 0x0B0(DIGIT_NUM-1) (scan limit), 0x0A0(brightness), 0x0F00 (test off), then goes to DIGITS with snapshot num=0, dp=000.
REQ-018 DIGITS sends DIGIT_NUM frames for addresses 1..DIGIT_NUM ascending; data = {dp_bit, 3'b000, nibble}. nibble = snapshot num[4*(i-1)+3 : 4*(i-1)] for address i. dp_bit = 1 only when i-1 equals snapshot dp.
REQ-019 dp values >= DIGIT_NUM SHALL set no decimal point.
REQ-020 num and dp SHALL be snapshotted on the cycle the FSM enters DIGITS; later input changes SHALL NOT affect the frames in flight.
REQ-021 BRIGHT sends one frame 0x0A0(b), b = brightness sampled on entry to BRIGHT; then returns to IDLE.
REQ-022 update_req and bright_req SHALL each set a one-deep pending flag in any state; repeated requests before service coalesce into one.
REQ-023 In IDLE with both flags set, BRIGHT SHALL be served first, then DIGITS; a flag clears on the cycle its state is entered.
REQ-024 A request arriving on the same cycle its flag is cleared SHALL leave the flag set.
REQ-025 Pending requests during INIT SHALL be served after INIT and its closing DIGITS pass, in the order of REQ-023.
REQ-026 Frames SHALL never be aborted or interleaved; a state change happens only after the last transfer of the current state.
REQ-027 IDLE -> next state takes one cycle; frame_valid rises on the first cycle in BRIGHT/DIGITS.

Reset
REQ-028 While reset is low at a clock edge: state=INIT with frame index 0, frame_valid=0, frame_data=16'h0000, busy=1, init_done=0, pending flags cleared, snapshots cleared.
REQ-029 On the first cycle with reset high, frame_valid=1 and frame_data=0x0C01.
REQ-030 Reset asserted during any transfer SHALL drop frame_valid at that edge and restart INIT from frame 0; the partial sequence is not resumed.

Verification
REQ-031 Reset release, frame_ready held 1, brightness=4'h5, DIGIT_NUM=8 -> frames 0C01, 09FF, 0B07, 0A05, 0F00, 0100..0800 on 13 consecutive cycles; init_done high and busy low after that.
REQ-032 From IDLE, update_req with num=32'h12345678, dp=3'b010 -> frames 0108, 0207, 0386, 0405, 0504, 0603, 0702, 0801.
REQ-033 frame_ready low for 4 cycles mid-DIGITS, num changed meanwhile -> frame_data held constant; remaining frames use the original snapshot.
REQ-034 update_req and bright_req on the same IDLE cycle, brightness=4'hF -> 0A0F first, then 8 digit frames; a second update_req during BRIGHT yields exactly one more 8-frame pass.
REQ-035 Reset low for one cycle during the 3rd DIGITS frame -> frame_valid=0 next cycle; sequence restarts with 0C01; init_done=0 until the new INIT completes.
REQ-036 dp=3'b111 with DIGIT_NUM=4 -> no frame has bit 7 set; scan-limit frame is 0B03.

Source files
------------

// File: rtl/max7219_sequencer.sv
// Frame sequencer for a MAX7219 LED driver: runs the power-up register init, then
// emits intensity and digit-register frames on request over a valid/ready handshake.
module max7219_sequencer #(
  parameter int DIGIT_NUM = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   update_req_i,
  input  logic [DIGIT_NUM*4-1:0] num_i,
  input  logic [2:0]             dp_i,
  input  logic                   bright_req_i,
  input  logic [3:0]             brightness_i,
  output logic [15:0]            frame_data_o,
  output logic                   frame_valid_o,
  input  logic                   frame_ready_i,
  output logic                   busy_o,
  output logic                   init_done_o
);

  typedef enum logic [1:0] {INIT, IDLE, BRIGHT, DIGITS} state_t;

  localparam logic [2:0] LAST_DIGIT = 3'(DIGIT_NUM - 1);
  localparam logic [3:0] SCAN_LIMIT = 4'(DIGIT_NUM - 1);
  localparam logic [2:0] LAST_INIT  = 3'd4;

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic                   pendUpd_q, pendUpd_d;
  logic                   pendBri_q, pendBri_d;
  logic                   initDone_q, initDone_d;
  logic                   armed_q;
  logic [DIGIT_NUM*4-1:0] numSnap_q, numSnap_d;
  logic [2:0]             dpSnap_q, dpSnap_d;
  logic [3:0]             briSnap_q, briSnap_d;

  logic [15:0] frame;
  logic [3:0]  nib;
  logic        dpBit;
  logic        valid;
  logic        xfer;

  // armed_q holds frame_valid low for the edge at which reset was sampled low.
  assign valid         = armed_q && (state_q != IDLE);
  assign xfer          = valid && frame_ready_i;
  assign frame_valid_o = valid;
  assign frame_data_o  = valid ? frame : 16'h0000;
  assign busy_o        = (state_q != IDLE);
  assign init_done_o   = initDone_q;

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < DIGIT_NUM; i++) begin
      if (idx_q == 3'(i)) nib = numSnap_q[4*i +: 4];
    end
    // idx_q never reaches DIGIT_NUM, so an out-of-range dp matches no digit.
    dpBit = (dpSnap_q == idx_q);
  end

  always_comb begin
    frame = 16'h0000;
    case (state_q)
      INIT: begin
        case (idx_q)
          3'd0:    frame = 16'h0C01;
          3'd1:    frame = 16'h09FF;
          3'd2:    frame = {8'h0B, 4'h0, SCAN_LIMIT};
          3'd3:    frame = {8'h0A, 4'h0, briSnap_q};
          default: frame = 16'h0F00;
        endcase
      end
      BRIGHT:  frame = {8'h0A, 4'h0, briSnap_q};
      DIGITS:  frame = {4'h0, 4'(idx_q) + 4'd1, dpBit, 3'b000, nib};
      default: frame = 16'h0000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pendUpd_d  = pendUpd_q | update_req_i;
    pendBri_d  = pendBri_q | bright_req_i;
    initDone_d = initDone_q;
    numSnap_d  = numSnap_q;
    dpSnap_d   = dpSnap_q;
    briSnap_d  = briSnap_q;
    case (state_q)
      INIT: begin
        if (xfer) begin
          if (idx_q == LAST_INIT) begin
            state_d    = DIGITS;
            idx_d      = 3'd0;
            numSnap_d  = '0;
            dpSnap_d   = 3'd0;
            initDone_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            // Capture intensity as the intensity frame comes up so it stays stable.
            if (idx_q == 3'd2) briSnap_d = brightness_i;
          end
        end
      end
      IDLE: begin
        idx_d = 3'd0;
        if (pendBri_q) begin
          state_d   = BRIGHT;
          briSnap_d = brightness_i;
          pendBri_d = bright_req_i;
        end else if (pendUpd_q) begin
          state_d   = DIGITS;
          numSnap_d = num_i;
          dpSnap_d  = dp_i;
          pendUpd_d = update_req_i;
        end
      end
      BRIGHT: begin
        if (xfer) state_d = IDLE;
      end
      DIGITS: begin
        if (xfer) begin
          if (idx_q == LAST_DIGIT) begin
            state_d = IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= INIT;
      idx_q      <= 3'd0;
      pendUpd_q  <= 1'b0;
      pendBri_q  <= 1'b0;
      initDone_q <= 1'b0;
      armed_q    <= 1'b0;
      numSnap_q  <= '0;
      dpSnap_q   <= 3'd0;
      briSnap_q  <= 4'h0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pendUpd_q  <= pendUpd_d;
      pendBri_q  <= pendBri_d;
      initDone_q <= initDone_d;
      armed_q    <= 1'b1;
      numSnap_q  <= numSnap_d;
      dpSnap_q   <= dpSnap_d;
      briSnap_q  <= briSnap_d;
    end
  end

endmodule

// File: tb/tb_max7219_sequencer.sv
// Scoreboard bench for max7219_sequencer: an 8-digit instance checked frame by frame
// and a 4-digit instance for scan limit and out-of-range decimal point.
module tb_max7219_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        updateReq = 1'b0;
  logic [31:0] num = 32'h0;
  logic [2:0]  dp = 3'd0;
  logic        brightReq = 1'b0;
  logic [3:0]  brightness = 4'h5;
  logic [15:0] frameData;
  logic        frameValid;
  logic        frameReady = 1'b1;
  logic        busy;
  logic        initDone;

  logic        update4 = 1'b0;
  logic [15:0] num4 = 16'h0;
  logic [2:0]  dp4 = 3'd0;
  logic [15:0] frameData4;
  logic        frameValid4;
  logic        busy4;
  logic        initDone4;

  logic [15:0] expQ[$];
  int checkCount = 0;
  int failCount = 0;
  int xferCount = 0;
  int digitCount4 = 0;
  bit dut4Check = 1'b0;
  bit prevHold = 1'b0;
  logic [15:0] prevData = 16'h0;

  always #5 clock = ~clock;

  max7219_sequencer #(.DIGIT_NUM(8)) dut (
    .clock(clock), .reset(reset), .update_req_i(updateReq), .num_i(num), .dp_i(dp),
    .bright_req_i(brightReq), .brightness_i(brightness), .frame_data_o(frameData),
    .frame_valid_o(frameValid), .frame_ready_i(frameReady), .busy_o(busy),
    .init_done_o(initDone)
  );

  max7219_sequencer #(.DIGIT_NUM(4)) dut4 (
    .clock(clock), .reset(reset), .update_req_i(update4), .num_i(num4), .dp_i(dp4),
    .bright_req_i(1'b0), .brightness_i(brightness), .frame_data_o(frameData4),
    .frame_valid_o(frameValid4), .frame_ready_i(1'b1), .busy_o(busy4),
    .init_done_o(initDone4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] digitFrame(input int i, input logic [31:0] n, input logic [2:0] d, input int digits);
    logic [3:0] nibVal;
    logic dpb;
    nibVal = n[4*(i-1) +: 4];
    dpb = (int'(d) == i - 1) && (int'(d) < digits);
    return {4'h0, 4'(i), dpb, 3'b000, nibVal};
  endfunction

  task automatic pushDigits(input logic [31:0] n, input logic [2:0] d);
    for (int i = 1; i <= 8; i++) expQ.push_back(digitFrame(i, n, d, 8));
  endtask

  task automatic pushInit(input logic [3:0] b);
    expQ.push_back(16'h0C01);
    expQ.push_back(16'h09FF);
    expQ.push_back(16'h0B07);
    expQ.push_back({8'h0A, 4'h0, b});
    expQ.push_back(16'h0F00);
    pushDigits(32'h0, 3'd0);
  endtask

  // One-cycle request pulse, driven just after a rising edge.
  task automatic applyStimulus(input bit upd, input bit bri, input logic [31:0] n, input logic [2:0] d, input logic [3:0] b);
    @(posedge clock); #1;
    num = n; dp = d; brightness = b;
    updateReq = upd; brightReq = bri;
    @(posedge clock); #1;
    updateReq = 1'b0; brightReq = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy && expQ.size() == 0) break;
    end
    checkOutput("idleBusy", 32'(busy), 32'd0);
    checkOutput("sbDrained", expQ.size(), 32'd0);
  endtask

  always @(negedge clock) begin
    if (reset && prevHold) begin
      checkOutput("holdValid", 32'(frameValid), 32'd1);
      checkOutput("holdData", 32'(frameData), 32'(prevData));
    end
    prevHold = reset && frameValid && !frameReady;
    prevData = frameData;
    if (reset && frameValid && frameReady) begin
      xferCount++;
      checkOutput("sbNonEmpty", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) checkOutput("frame", 32'(frameData), 32'(expQ.pop_front()));
    end
  end

  always @(negedge clock) begin
    if (reset && frameValid4) begin
      if (frameData4[11:8] == 4'hB) checkOutput("dut4Scan", 32'(frameData4[7:0]), 32'h03);
      if (dut4Check && frameData4[11:8] >= 4'd1 && frameData4[11:8] <= 4'd4) begin
        digitCount4++;
        checkOutput("dut4Dp", 32'(frameData4[7]), 32'd0);
        checkOutput("dut4Nib", 32'(frameData4[3:0]), 32'(num4[4*(int'(frameData4[11:8])-1) +: 4]));
      end
    end
  end

  initial begin
    int base;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rstValid", 32'(frameValid), 32'd0);
    checkOutput("rstData", 32'(frameData), 32'h0000);
    checkOutput("rstBusy", 32'(busy), 32'd1);
    checkOutput("rstInitDone", 32'(initDone), 32'd0);

    // Init sequence with continuous ready
    pushInit(4'h5);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      if (i == 0) checkOutput("firstFrame", 32'(frameData), 32'h0C01);
      checkOutput("initValid", 32'(frameValid), 32'd1);
    end
    @(negedge clock);
    checkOutput("initBusy", 32'(busy), 32'd0);
    checkOutput("initDone", 32'(initDone), 32'd1);
    checkOutput("initDrained", expQ.size(), 32'd0);

    // Plain digit update with a decimal point on digit 3
    expQ.push_back(16'h0108); expQ.push_back(16'h0207);
    expQ.push_back(16'h0386); expQ.push_back(16'h0405);
    expQ.push_back(16'h0504); expQ.push_back(16'h0603);
    expQ.push_back(16'h0702); expQ.push_back(16'h0801);
    applyStimulus(1'b1, 1'b0, 32'h12345678, 3'b010, 4'h5);
    waitIdle(40);

    // Stall mid-pass while num changes underneath
    pushDigits(32'hA1B2C3D4, 3'd5);
    base = xferCount;
    applyStimulus(1'b1, 1'b0, 32'hA1B2C3D4, 3'd5, 4'h5);
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (xferCount >= base + 3) break;
    end
    checkOutput("stallReach", 32'(xferCount >= base + 3), 32'd1);
    frameReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      num = $urandom;
    end
    frameReady = 1'b1;
    waitIdle(40);

    // Simultaneous requests, then a second update during the intensity frame
    num = 32'h0F1E2D3C; dp = 3'd7;
    expQ.push_back(16'h0A0F);
    pushDigits(32'h0F1E2D3C, 3'd7);
    applyStimulus(1'b1, 1'b1, 32'h0F1E2D3C, 3'd7, 4'hF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (frameValid) break;
    end
    checkOutput("brightFrame", 32'(frameData), 32'h0A0F);
    updateReq = 1'b1;
    @(posedge clock); #1;
    updateReq = 1'b0;
    waitIdle(60);
    repeat (5) @(negedge clock);
    checkOutput("noExtraPass", 32'(busy), 32'd0);

    // Request held across the serve edge survives as one more pass
    pushDigits(32'h00009999, 3'd0);
    pushDigits(32'h00009999, 3'd0);
    @(posedge clock); #1;
    num = 32'h00009999; dp = 3'd0;
    updateReq = 1'b1;
    repeat (2) @(posedge clock);
    #1 updateReq = 1'b0;
    waitIdle(80);

    // Intensity-only request
    expQ.push_back(16'h0A03);
    applyStimulus(1'b0, 1'b1, 32'h00009999, 3'd0, 4'h3);
    waitIdle(20);

    // Reset during the third digit frame
    brightness = 4'hF;
    pushDigits(32'h87654321, 3'd1);
    base = xferCount;
    applyStimulus(1'b1, 1'b0, 32'h87654321, 3'd1, 4'hF);
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (xferCount >= base + 2) break;
    end
    checkOutput("rstReach", 32'(xferCount), 32'(base + 2));
    reset = 1'b0;
    @(posedge clock); #1;
    expQ.delete();
    pushInit(4'hF);
    @(negedge clock);
    checkOutput("midRstValid", 32'(frameValid), 32'd0);
    checkOutput("midRstDone", 32'(initDone), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("restartFrame", 32'(frameData), 32'h0C01);
    checkOutput("restartDone", 32'(initDone), 32'd0);
    waitIdle(40);
    checkOutput("restartDoneEnd", 32'(initDone), 32'd1);

    // Four-digit instance, decimal point out of range
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busy4) break;
    end
    dut4Check = 1'b1;
    @(posedge clock); #1;
    num4 = 16'h9876; dp4 = 3'd7; update4 = 1'b1;
    @(posedge clock); #1;
    update4 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (digitCount4 >= 4 && !busy4) break;
    end
    repeat (4) @(negedge clock);
    checkOutput("dut4Count", digitCount4, 32'd4);
    checkOutput("dut4Idle", 32'(busy4), 32'd0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
